// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the Hamming(16,11) SECDED receive path.
//   CW_W / DATA_W : codeword and data widths
//   health_t      : link-health encoding (OK / DEGRADED / FAILED)
//   DATA_POS      : codeword bit positions that carry data, LSB data bit first
//   extract_data  : strips the five parity positions (0, 1, 2, 4, 8)
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam int CW_W   = 16;
    localparam int DATA_W = 11;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        DEGRADED = 2'b01,
        FAILED   = 2'b10
    } health_t;

    localparam logic [3:0] DATA_POS [DATA_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_sync_fifo.sv
// -----------------------------------------------------------------------------
// hamming_sync_fifo
// Single-clock FIFO with valid/ready on both sides, no write-to-read bypass.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    write side; in_ready = not full
//   out_valid/out_ready/out_data read side; out_data is zero while empty
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
// -----------------------------------------------------------------------------
module hamming_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Both flags come from registered pointers only, so in_ready has no
    // combinational path from out_ready; a pop on a full FIFO frees the slot
    // one cycle later.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    // Gating with empty makes out_data read 0 out of reset even though the
    // storage itself is never cleared.
    assign out_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are
    // live, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

endmodule

// File: rtl/hamming_rx_monitor.sv
// -----------------------------------------------------------------------------
// hamming_rx_monitor
// Receive stage behind the Hamming(16,11) SECDED decoder: extracts the 11 data
// bits, buffers them for the consumer, counts corrected/uncorrectable words and
// tracks a sticky link-health state.
// Parameters: DEPTH (FIFO entries), CNT_W (counter width),
//             SEC_THRESH (corrected count that degrades health).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           decoder handshake
//   in_codeword, in_sed, in_ded decoded word and its error flags
//   out_valid/out_ready         consumer handshake
//   out_data, out_corrected     extracted data and its corrected flag
//   sec_count, ded_count        saturating error counters
//   clear_counts                synchronous clear of counters and health
//   health                      00 OK, 01 DEGRADED, 10 FAILED
// Build option HAMMING_MON_DED_FWD_EN: forward uncorrectable words instead of
// dropping them, tagged on the extra output out_ded.
// -----------------------------------------------------------------------------
module hamming_rx_monitor
    import hamming_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 8,
    parameter int SEC_THRESH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_codeword,
    input  logic              in_sed,
    input  logic              in_ded,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    input  logic              clear_counts,
    output logic [1:0]        health
`ifdef HAMMING_MON_DED_FWD_EN
    ,
    output logic              out_ded
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(SEC_THRESH);

    logic              accept;
    logic              is_ded;
    logic              is_sec;
    logic              fifo_in_valid;
    logic [CNT_W-1:0]  sec_next;
    logic [CNT_W-1:0]  ded_next;
    health_t           state;
    health_t           state_next;

    // DED outranks SED: a word flagged with both is uncorrectable.
    assign is_ded = in_ded;
    assign is_sec = in_sed && !in_ded;
    assign accept = in_valid && in_ready;

`ifdef HAMMING_MON_DED_FWD_EN
    localparam int WORD_W = DATA_W + 2;
    logic [WORD_W-1:0] fifo_in_data;
    logic [WORD_W-1:0] fifo_out_data;
    assign fifo_in_valid = in_valid;
    assign fifo_in_data  = {is_ded, is_sec, extract_data(in_codeword)};
    assign {out_ded, out_corrected, out_data} = fifo_out_data;
`else
    localparam int WORD_W = DATA_W + 1;
    logic [WORD_W-1:0] fifo_in_data;
    logic [WORD_W-1:0] fifo_out_data;
    // DED words still complete the handshake; they just never reach the FIFO.
    assign fifo_in_valid = in_valid && !is_ded;
    assign fifo_in_data  = {is_sec, extract_data(in_codeword)};
    assign {out_corrected, out_data} = fifo_out_data;
`endif

    logic fifo_in_ready;

    hamming_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fifo_in_valid),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out_data)
    );

    // Acceptance is gated on FIFO space for every word, dropped or not.
    assign in_ready = fifo_in_ready;

    // Clear is applied first, then the accepted word is counted and the
    // health transition is evaluated from the cleared state.
    always_comb begin
        // NOTE: every signal gets its default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        sec_next   = clear_counts ? '0 : sec_count;
        ded_next   = clear_counts ? '0 : ded_count;
        state_next = clear_counts ? OK : state;
        if (accept && is_ded) begin
            if (ded_next != CNT_MAX) ded_next = ded_next + 1'b1;
            state_next = FAILED;
        end else if (accept && is_sec) begin
            if (sec_next != CNT_MAX) sec_next = sec_next + 1'b1;
            if (state_next == OK && sec_next >= THRESH) state_next = DEGRADED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_count <= '0;
            ded_count <= '0;
            state     <= OK;
        end else begin
            sec_count <= sec_next;
            ded_count <= ded_next;
            state     <= state_next;
        end
    end

    assign health = state;

endmodule

// File: tb/tb_hamming_rx_monitor.sv
// -----------------------------------------------------------------------------
// tb_hamming_rx_monitor
// Self-checking bench for hamming_rx_monitor (DEPTH=4, CNT_W=2, SEC_THRESH=2).
// A reference model (queue of expected words, integer counters, health code)
// is advanced at every clock edge from the driven inputs; DUT outputs are
// compared 1 time unit after the edge. Honours HAMMING_MON_DED_FWD_EN.
// -----------------------------------------------------------------------------
module tb_hamming_rx_monitor;

    localparam int DEPTH      = 4;
    localparam int CNT_W      = 2;
    localparam int SEC_THRESH = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef HAMMING_MON_DED_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_codeword = '0;
    logic              in_sed = 1'b0;
    logic              in_ded = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [10:0]       out_data;
    logic              out_corrected;
    logic [CNT_W-1:0]  sec_count;
    logic [CNT_W-1:0]  ded_count;
    logic              clear_counts = 1'b0;
    logic [1:0]        health;
    logic              ded_flag;

    hamming_rx_monitor #(
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .SEC_THRESH (SEC_THRESH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_codeword   (in_codeword),
        .in_sed        (in_sed),
        .in_ded        (in_ded),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .sec_count     (sec_count),
        .ded_count     (ded_count),
        .clear_counts  (clear_counts),
        .health        (health)
`ifdef HAMMING_MON_DED_FWD_EN
        ,
        .out_ded       (ded_flag)
`endif
    );

`ifndef HAMMING_MON_DED_FWD_EN
    assign ded_flag = 1'b0;
`endif

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [10:0] data;
        logic        corr;
        logic        ded;
    } word_t;

    word_t exp_q[$];
    int    m_sec;
    int    m_ded;
    int    m_health;   // 0 OK, 1 DEGRADED, 2 FAILED
    int    n_checks = 0;
    int    n_fail   = 0;

    // Data bits live at every position that is not 0 and not a power of two.
    function automatic logic [10:0] ref_extract(input logic [15:0] cw);
        logic [10:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 0; p < 16; p++) begin
            if ($countones(p) >= 2) begin
                d[k] = cw[p];
                k++;
            end
        end
        return d;
    endfunction

    task automatic m_reset();
        exp_q.delete();
        m_sec    = 0;
        m_ded    = 0;
        m_health = 0;
    endtask

    task automatic model_edge();
        bit    acc;
        bit    pop;
        word_t w;
        if (rst) begin
            m_reset();
            return;
        end
        acc = in_valid && (exp_q.size() < DEPTH);
        pop = (exp_q.size() > 0) && out_ready;
        if (pop) void'(exp_q.pop_front());
        if (clear_counts) begin
            m_sec    = 0;
            m_ded    = 0;
            m_health = 0;
        end
        if (acc) begin
            w.data = ref_extract(in_codeword);
            w.ded  = in_ded;
            w.corr = in_sed && !in_ded;
            if (in_ded) begin
                if (m_ded < CNT_MAX) m_ded++;
                m_health = 2;
                if (FWD) exp_q.push_back(w);
            end else begin
                if (in_sed) begin
                    if (m_sec < CNT_MAX) m_sec++;
                    if (m_health == 0 && m_sec >= SEC_THRESH) m_health = 1;
                end
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] cw, input logic sed,
                         input logic ded, input logic ordy, input logic clr);
        in_valid     = v;
        in_codeword  = cw;
        in_sed       = sed;
        in_ded       = ded;
        out_ready    = ordy;
        clear_counts = clr;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 11'h000) begin n_fail++; $display("FAIL reset_out_data: got %h want 000", out_data); end
        n_checks++; if (out_corrected !== 1'b0) begin n_fail++; $display("FAIL reset_out_corrected: got %b want 0", out_corrected); end
        n_checks++; if (sec_count !== 2'd0) begin n_fail++; $display("FAIL reset_sec_count: got %0d want 0", sec_count); end
        n_checks++; if (ded_count !== 2'd0) begin n_fail++; $display("FAIL reset_ded_count: got %0d want 0", ded_count); end
        n_checks++; if (health !== 2'b00) begin n_fail++; $display("FAIL reset_health: got %b want 00", health); end
        n_checks++; if (ded_flag !== 1'b0) begin n_fail++; $display("FAIL reset_out_ded: got %b want 0", ded_flag); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean();
        drive(1'b1, 16'hFFF7, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_latency_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 11'h7FE) begin n_fail++; $display("FAIL clean_data: got %h want 7fe", out_data); end
        n_checks++; if (out_corrected !== 1'b0) begin n_fail++; $display("FAIL clean_corrected: got %b want 0", out_corrected); end
        n_checks++; if (sec_count !== 2'd0 || ded_count !== 2'd0) begin n_fail++; $display("FAIL clean_counts: got %0d/%0d want 0/0", sec_count, ded_count); end
        n_checks++; if (health !== 2'b00) begin n_fail++; $display("FAIL clean_health: got %b want 00", health); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_full();
        logic [10:0] e;
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            n_checks++; if (in_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL full_in_ready_%0d: got %b want %b", i, in_ready, exp_q.size() < DEPTH); end
        end
        n_checks++; if (exp_q.size() != DEPTH || out_valid !== 1'b1) begin n_fail++; $display("FAIL full_occupancy: model %0d out_valid %b want %0d/1", exp_q.size(), out_valid, DEPTH); end
        // Full with a pop in the same cycle: the offered word must be refused.
        drive(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (in_ready !== 1'b1 || exp_q.size() != DEPTH - 1) begin n_fail++; $display("FAIL full_pop_no_push: in_ready %b model %0d want 1/%0d", in_ready, exp_q.size(), DEPTH - 1); end
        while (exp_q.size() > 0) begin
            e = exp_q[0].data;
            n_checks++; if (out_valid !== 1'b1 || out_data !== e) begin n_fail++; $display("FAIL full_drain_order: got %b/%h want 1/%h", out_valid, out_data, e); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_sec();
        logic [10:0] e;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (sec_count !== 2'd1 || health !== 2'b00) begin n_fail++; $display("FAIL sec_below_thresh: got %0d/%b want 1/00", sec_count, health); end
        drive(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (sec_count !== 2'd2) begin n_fail++; $display("FAIL sec_count: got %0d want 2", sec_count); end
        n_checks++; if (health !== 2'b01) begin n_fail++; $display("FAIL sec_degraded: got %b want 01", health); end
        while (exp_q.size() > 0) begin
            e = exp_q[0].data;
            n_checks++; if (out_data !== e || out_corrected !== 1'b1) begin n_fail++; $display("FAIL sec_forward: got %h/%b want %h/1", out_data, out_corrected, e); end
            tick();
        end
    endtask

    task automatic test_ded();
        logic [10:0] e;
        drive(1'b1, 16'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        e = ref_extract(in_codeword);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (ded_count !== 2'd1) begin n_fail++; $display("FAIL ded_count: got %0d want 1", ded_count); end
        n_checks++; if (sec_count !== 2'd2) begin n_fail++; $display("FAIL ded_sec_unchanged: got %0d want 2", sec_count); end
        n_checks++; if (health !== 2'b10) begin n_fail++; $display("FAIL ded_failed: got %b want 10", health); end
        if (FWD) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== e || ded_flag !== 1'b1 || out_corrected !== 1'b0) begin n_fail++; $display("FAIL ded_forward: got %b/%h/%b/%b want 1/%h/1/0", out_valid, out_data, ded_flag, out_corrected, e); end
        end else begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ded_dropped: got %b want 0", out_valid); end
        end
        out_ready = 1'b1;
        tick();
        // FAILED is sticky across clean traffic.
        drive(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++; if (health !== 2'b10) begin n_fail++; $display("FAIL ded_sticky: got %b want 10", health); end
    endtask

    task automatic test_saturate();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        n_checks++; if (sec_count !== 2'd3) begin n_fail++; $display("FAIL sat_sec_count: got %0d want 3", sec_count); end
        n_checks++; if (health !== 2'b01) begin n_fail++; $display("FAIL sat_health: got %b want 01", health); end
        drive(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++; if (ded_count !== 2'd1 || sec_count !== 2'd0 || health !== 2'b10) begin n_fail++; $display("FAIL clear_with_ded: got %0d/%0d/%b want 1/0/10", ded_count, sec_count, health); end
        drive(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        n_checks++; if (sec_count !== 2'd1 || ded_count !== 2'd0 || health !== 2'b00) begin n_fail++; $display("FAIL clear_with_sec: got %0d/%0d/%b want 1/0/00", sec_count, ded_count, health); end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
    endtask

    task automatic test_mid_reset();
        logic [10:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), i[0], 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || sec_count === 2'd0) begin n_fail++; $display("FAIL mreset_pre: got %b/%0d want 1/nonzero", out_valid, sec_count); end
        #2 rst = 1'b1;
        m_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mreset_fifo: got %b/%b want 0/1", out_valid, in_ready); end
        n_checks++; if (sec_count !== 2'd0 || ded_count !== 2'd0 || health !== 2'b00) begin n_fail++; $display("FAIL mreset_counts: got %0d/%0d/%b want 0/0/00", sec_count, ded_count, health); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        e = ref_extract(in_codeword);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_data !== e) begin n_fail++; $display("FAIL mreset_latency: got %b/%h want 1/%h", out_valid, out_data, e); end
        tick();
    endtask

    task automatic test_random();
        word_t       w;
        logic [1:0]  es;
        logic [1:0]  ed;
        logic [1:0]  eh;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
            tick();
            if (exp_q.size() > 0) w = exp_q[0];
            else begin w.data = '0; w.corr = 1'b0; w.ded = 1'b0; end
            es = m_sec[1:0];
            ed = m_ded[1:0];
            eh = m_health[1:0];
            n_checks++; if (in_ready !== (exp_q.size() < DEPTH) || out_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rand_flags c%0d: got %b/%b want %b/%b", c, in_ready, out_valid, exp_q.size() < DEPTH, exp_q.size() > 0); end
            n_checks++; if (out_data !== w.data || out_corrected !== w.corr || ded_flag !== (FWD & w.ded)) begin n_fail++; $display("FAIL rand_word c%0d: got %h/%b/%b want %h/%b/%b", c, out_data, out_corrected, ded_flag, w.data, w.corr, FWD & w.ded); end
            n_checks++; if (sec_count !== es || ded_count !== ed || health !== eh) begin n_fail++; $display("FAIL rand_status c%0d: got %0d/%0d/%b want %0d/%0d/%b", c, sec_count, ded_count, health, es, ed, eh); end
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_full();
        test_sec();
        test_ded();
        test_saturate();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_rx_monitor.md
# hamming_rx_monitor

Receive-side stage that sits directly downstream of the combinational Hamming(16,11) SECDED decoder. Each cycle it accepts one decoded codeword and its single-error (SED, corrected) and double-error (DED, uncorrectable) flags through a valid/ready handshake. It strips the five parity bits to recover the 11 data bits and buffers them in a small FIFO for the consumer. It also keeps saturating error counters and a sticky link-health state machine.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of each error counter.
- `SEC_THRESH`, 16: corrected-error count at which health becomes DEGRADED; 1 ≤ SEC_THRESH ≤ 2^CNT_W−1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  decoder word valid.
- `in_ready`  out  1  stage can accept a word.
- `in_codeword`  in  16  corrected codeword from the decoder (bit n = position n).
- `in_sed`  in  1  single error detected and corrected.
- `in_ded`  in  1  double error detected.
- `out_valid`  out  1  data word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  11  extracted data bits.
- `out_corrected`  out  1  word had a corrected single error.
- `sec_count`  out  CNT_W  accepted words with a corrected error.
- `ded_count`  out  CNT_W  accepted words with an uncorrectable error.
- `clear_counts`  in  1  synchronous clear of the counters and health state.
- `health`  out  2  00 OK, 01 DEGRADED, 10 FAILED.

## Operation
- Accept happens when `in_valid && in_ready`. Pop happens when `out_valid && out_ready`.
- Data extraction: `out_data[i]` = `in_codeword[pos[i]]`, with pos = {3,5,6,7,9,10,11,12,13,14,15} for i = 0..10. Positions 0, 1, 2, 4 and 8 are discarded.
- Error classification: DED has priority. If `in_ded`=1, the word is DED regardless of `in_sed`. If `in_sed`=1 and `in_ded`=0, the word is SEC. Otherwise the word is clean.
- Accepted clean and SEC words are pushed into the FIFO with a `corrected` bit equal to the SEC classification.
- Accepted DED words are dropped: nothing is pushed.
- Counter updates on accept:
  - `sec_count` increments on a SEC word.
  - `ded_count` increments on a DED word.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- Health FSM:
  - OK → DEGRADED when the updated `sec_count` ≥ SEC_THRESH.
  - OK or DEGRADED → FAILED on any accepted DED word.
  - FAILED is sticky. DEGRADED never returns to OK on its own.
  - Only `clear_counts` or `rst` returns the FSM to OK.
- `clear_counts` in the same cycle as an accepted error: the clear applies first, then the event is counted. The counter becomes 1, and the FSM evaluates from OK (a DED goes to FAILED; a SEC goes to DEGRADED only if SEC_THRESH = 1).
- `clear_counts` never affects the FIFO.
- A mid-operation reset empties the FIFO immediately and discards all buffered words.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_corrected`=0, `sec_count`=0, `ded_count`=0, `health`=00.
- `in_ready` = FIFO not full. It is registered-state derived, with no combinational path from `out_ready`.
- Full FIFO with a pop in the same cycle: `in_ready` stays 0 that cycle, so a push is not accepted.
- Latency: a word accepted at edge N is visible on `out_valid`/`out_data` after edge N, i.e. 1 cycle.
- Empty FIFO with an accepted word: `out_valid` rises the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged.
- Outputs hold stable while `out_valid && !out_ready`.
- Counters and `health` update on the edge of the accept. They are readable the next cycle.
- Pointers are log2(DEPTH)+1 bits wide. Full/empty is determined by the MSB compare, and the pointers wrap naturally.

## Configuration
- `HAMMING_MON_DED_FWD_EN`:
  - When defined, DED words are pushed into the FIFO instead of dropped, and an extra output `out_ded` (1 bit, reset 0) marks them. `out_corrected` is 0 for DED words. Counters and FSM behave the same.
  - When undefined, DED words are dropped and the `out_ded` port does not exist.

## Structure
- Shared package `hamming_pkg`:
  - `health_t` enum: OK=2'b00, DEGRADED=2'b01, FAILED=2'b10.
  - `DATA_POS` constant array of the 11 data positions.
  - `extract_data()` function.
  - Widths: `CW_W`=16, `DATA_W`=11.
- One sub-module: `hamming_sync_fifo` (DEPTH, WIDTH parameters, valid/ready on both sides). The top level holds extraction, counters and the FSM.

## Test plan
- Reset, then push `in_codeword`=16'hFFF7 clean with `out_ready`=1 → one cycle later `out_data`=11'h7FE, `out_corrected`=0, counters 0, health OK.
- Hold `out_ready`=0 and push DEPTH+1 words → `in_ready` drops after DEPTH accepts. The extra word is not accepted. Draining returns the words in order.
- SEC_THRESH=2, push 2 words with `in_sed`=1 → `sec_count`=2, health DEGRADED, data forwarded with `out_corrected`=1.
- Push `in_sed`=1, `in_ded`=1 → `ded_count`=1, `sec_count` unchanged, health FAILED, nothing forwarded (macro off); forwarded with `out_ded`=1 (macro on).
- CNT_W=2, push 5 SEC words → `sec_count` saturates at 3. `clear_counts` together with a DED accept → `ded_count`=1, `sec_count`=0, health FAILED.
- Assert `rst` with 3 words buffered → `out_valid`=0 and counters 0 immediately; the next push has 1-cycle latency.
